// File: rtl/drc_pipe_reg.sv
// drc_pipe_reg: elastic pipeline of DEPTH stages. Words move forward whenever
// the stage ahead is empty or moving, so bubbles compact out under backpressure.
// The input is stalled only when every stage is full and the output is stalled.
// Data registers carry no reset; only the valid bits and the occupancy count do.
// The data output is named dout because "do" is a reserved word.
// Optional build macro: DRC_PIPE_CHECK_EN adds elaboration-time parameter checks.
module drc_pipe_reg #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 3,
    parameter     DEVICE = "virtex6"
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           di,
    input  logic                       di_vld,
    output logic                       di_rdy,
    output logic [WIDTH-1:0]           dout,
    output logic                       do_vld,
    input  logic                       do_rdy,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_nxt;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] data [DEPTH];
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;

`ifdef DRC_PIPE_CHECK_EN
    // Reject unsupported parameter sets before any simulation time elapses.
    initial begin
        if (DEVICE != "virtex6") begin
            $display("DRC ERROR: DEVICE=%s unsupported, expected virtex6", DEVICE);
            $finish;
        end
        if (WIDTH < 8) begin
            $display("DRC ERROR: WIDTH=%0d below minimum 8", WIDTH);
            $finish;
        end
        if (DEPTH < 1) begin
            $display("DRC ERROR: DEPTH=%0d below minimum 1", DEPTH);
            $finish;
        end
        if (DEPTH > 16) begin
            $display("DRC ERROR: DEPTH=%0d above maximum 16", DEPTH);
            $finish;
        end
    end
`else
    // Device family only matters to the rule checks; the structure is generic.
    if (DEVICE != "virtex6") begin : g_other_device
    end
`endif

    // Advance chain: a stage loads when it is empty or its word moves on,
    // rippling back combinationally from do_rdy.
    always_comb begin
        logic chain;
        chain = !vld[DEPTH-1] || do_rdy;
        adv = '0;
        adv[DEPTH-1] = chain;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            chain  = !vld[k] || chain;
            adv[k] = chain;
        end
    end

    // Next valid bits and their population count, so count tracks the stages exactly.
    always_comb begin
        vld_nxt = vld;
        cnt_nxt = '0;
        if (adv[0]) vld_nxt[0] = di_vld;
        for (int k = 1; k < DEPTH; k++) begin
            if (adv[k]) vld_nxt[k] = vld[k-1];
        end
        for (int k = 0; k < DEPTH; k++) begin
            cnt_nxt = cnt_nxt + CW'(vld_nxt[k]);
        end
    end

    // Valid bits and count: reset beats flush, flush beats any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            cnt <= '0;
        end else if (flush) begin
            vld <= '0;
            cnt <= '0;
        end else begin
            vld <= vld_nxt;
            cnt <= cnt_nxt;
        end
    end

    // Data shift; stale contents are harmless because the valid bits gate them.
    always_ff @(posedge clk) begin
        if (adv[0]) data[0] <= di;
        for (int k = 1; k < DEPTH; k++) begin
            if (adv[k]) data[k] <= data[k-1];
        end
    end

    assign di_rdy = adv[0];
    assign dout   = data[DEPTH-1];
    assign do_vld = vld[DEPTH-1];
    assign count  = cnt;

endmodule

// File: tb/tb_drc_pipe_reg.sv
// Randomized and directed bench for drc_pipe_reg. The reference model tracks
// each in-flight word and its position along the pipe.
module tb_drc_pipe_reg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] di = '0;
    logic             di_vld = 1'b0;
    logic             di_rdy;
    logic [WIDTH-1:0] dout;
    logic             do_vld;
    logic             do_rdy = 1'b0;
    logic [CW-1:0]    count;

    drc_pipe_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DEVICE("virtex6")) dut (
        .clk(clk), .rst(rst), .flush(flush), .di(di), .di_vld(di_vld),
        .di_rdy(di_rdy), .dout(dout), .do_vld(do_vld), .do_rdy(do_rdy),
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] word;
        int               pos;
    } item_t;

    item_t mq[$];
    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int first_out, last_out, n_out;
    int lat;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: compare the DUT against the model on the falling edge,
    // advance the model with the inputs held for this cycle, then step past the edge.
    task automatic step();
        bit exp_vld, pop, exp_rdy;
        int lim;
        @(negedge clk);
        exp_vld = (mq.size() > 0) && (mq[0].pos == DEPTH - 1);
        check("do_vld", {31'd0, do_vld}, {31'd0, exp_vld});
        if (exp_vld) check("dout", {24'd0, dout}, {24'd0, mq[0].word});
        check("count", {{(32-CW){1'b0}}, count}, mq.size());
        pop = exp_vld && do_rdy;
        if (pop) begin
            if (n_out == 0) first_out = cyc;
            last_out = cyc;
            n_out++;
            void'(mq.pop_front());
        end
        for (int i = 0; i < mq.size(); i++) begin
            lim = (i == 0) ? DEPTH - 1 : mq[i-1].pos - 1;
            mq[i].pos = (mq[i].pos + 1 < lim) ? mq[i].pos + 1 : lim;
        end
        exp_rdy = (mq.size() == 0) || (mq[mq.size()-1].pos >= 1);
        check("di_rdy", {31'd0, di_rdy}, {31'd0, exp_rdy});
        if (di_vld && exp_rdy) mq.push_back('{word: di, pos: 0});
        if (rst || flush) mq.delete();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset_count", {{(32-CW){1'b0}}, count}, 0);
        check("reset_do_vld", {31'd0, do_vld}, 0);
        check("reset_di_rdy", {31'd0, di_rdy}, 1);

        // Single word latency on an empty pipe.
        do_rdy = 1'b1;
        di = 8'h11;
        di_vld = 1'b1;
        step();
        di_vld = 1'b0;
        lat = 1;
        while (!do_vld && lat < 10) begin
            step();
            lat++;
        end
        check("latency", lat, DEPTH);
        check("latency_word", {24'd0, dout}, 32'h11);
        step();
        check("drained_count", {{(32-CW){1'b0}}, count}, 0);

        // Back-to-back stream with no gaps.
        n_out = 0;
        for (int w = 1; w <= 32; w++) begin
            di = w[WIDTH-1:0];
            di_vld = 1'b1;
            step();
        end
        di_vld = 1'b0;
        for (int w = 0; w < DEPTH + 2; w++) step();
        check("stream_words", n_out, 32);
        check("stream_gapless", last_out - first_out, 31);

        // Backpressure: three words fill the pipe, the fourth waits.
        do_rdy = 1'b0;
        for (int w = 0; w < 4; w++) begin
            di = 8'hA0 + 8'(w);
            di_vld = 1'b1;
            for (int t = 0; t < 20 && !(di_rdy && w < 3); t++) begin
                if (w == 3 && t == 3) break;
                step();
            end
            if (w < 3) step();
        end
        check("full_count", {{(32-CW){1'b0}}, count}, DEPTH);
        check("full_di_rdy", {31'd0, di_rdy}, 0);
        do_rdy = 1'b1;
        step();
        di_vld = 1'b0;
        for (int t = 0; t < 8; t++) step();

        // Flush a full pipe while a word is offered.
        do_rdy = 1'b0;
        for (int w = 0; w < DEPTH; w++) begin
            di = 8'hC0 + 8'(w);
            di_vld = 1'b1;
            step();
        end
        di = 8'hCF;
        do_rdy = 1'b1;
        flush = 1'b1;
        step();
        flush = 1'b0;
        di_vld = 1'b0;
        check("flush_count", {{(32-CW){1'b0}}, count}, 0);
        check("flush_do_vld", {31'd0, do_vld}, 0);
        for (int t = 0; t < 6; t++) step();

        // Reset in the middle of a burst, then one word afterwards.
        for (int w = 0; w < 5; w++) begin
            di = 8'h50 + 8'(w);
            di_vld = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_count", {{(32-CW){1'b0}}, count}, 0);
        check("rst_do_vld", {31'd0, do_vld}, 0);
        di = 8'h77;
        step();
        di_vld = 1'b0;
        lat = 1;
        while (!do_vld && lat < 10) begin
            step();
            lat++;
        end
        check("rst_latency", lat, DEPTH);
        check("rst_word", {24'd0, dout}, 32'h77);

        // Random traffic with occasional flush and reset.
        for (int t = 0; t < 600; t++) begin
            di     = 8'($urandom);
            di_vld = ($urandom_range(0, 3) != 0);
            do_rdy = ($urandom_range(0, 2) != 0);
            flush  = ($urandom_range(0, 40) == 0);
            rst    = ($urandom_range(0, 80) == 0);
            step();
        end
        rst = 1'b0;
        flush = 1'b0;
        di_vld = 1'b0;
        do_rdy = 1'b1;
        for (int t = 0; t < 6; t++) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
